// File: rtl/execute_muldiv.sv
// Iterative RISC-V M-extension unit: shift-add multiply and restoring divide, one bit per cycle.
// Accepts one op on a valid/ready handshake and holds the result until the consumer takes it.
module execute_muldiv #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [7:0]       md_op_i,
  input  logic             word_i,
  input  logic [XLEN-1:0]  rs1_data_i,
  input  logic [XLEN-1:0]  rs2_data_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  out_data_o,
  output logic [TAG_W-1:0] out_tag_o,
  output logic             busy_o,
  output logic [1:0]       dbg_state_o
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam int PW = 2 * XLEN;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_DONE = 2'd2} state_t;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid never depends on ready, and the result is held unchanged while out_valid_o waits.

  // Replace bits above 31 with bit 31 (s=1) or zeros (s=0).
  function automatic logic [XLEN-1:0] ext32(input logic [XLEN-1:0] x, input logic s);
    logic [XLEN-1:0] r;
    r = x;
    for (int i = 32; i < XLEN; i++) r[i] = s & x[31];
    return r;
  endfunction

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic              r_word, r_is_div, r_is_rem, r_mul_hi, r_neg_a, r_neg_r;
  logic [PW-1:0]     r_prod, r_mcand;
  logic [XLEN-1:0]   r_mplier, r_rem, r_quo, r_dvs;

  logic [7:0]        w_op;
  logic              w_word, w_is_mul, w_is_div, w_is_rem, w_mul_hi, w_s1, w_s2;
  logic              w_neg1, w_neg2, w_dz, w_ovf, w_special;
  logic [XLEN-1:0]   w_op1, w_op2, w_mag1, w_mag2, w_min_mag, w_special_res;

  // Lowest set bit of the one-hot op wins.
  assign w_op     = md_op_i & (~md_op_i + 8'd1);
  assign w_word   = (XLEN == 64) ? word_i : 1'b0;
  assign w_is_mul = |w_op[3:0];
  assign w_mul_hi = (|w_op[3:1]) & ~w_word;
  assign w_is_div = w_op[4] | w_op[5];
  assign w_is_rem = w_op[6] | w_op[7];
  assign w_s1     = w_op[1] | w_op[2] | w_op[4] | w_op[6];
  assign w_s2     = w_op[1] | w_op[4] | w_op[6];

  assign w_op1     = w_word ? ext32(rs1_data_i, w_s1) : rs1_data_i;
  assign w_op2     = w_word ? ext32(rs2_data_i, w_s2) : rs2_data_i;
  assign w_neg1    = w_s1 & w_op1[XLEN-1];
  assign w_neg2    = w_s2 & w_op2[XLEN-1];
  assign w_mag1    = w_neg1 ? -w_op1 : w_op1;
  assign w_mag2    = w_neg2 ? -w_op2 : w_op2;
  assign w_min_mag = w_word ? (XLEN'(1) << 31) : (XLEN'(1) << (XLEN - 1));

  assign w_dz      = (w_is_div | w_is_rem) & (w_op2 == '0);
  assign w_ovf     = (w_is_div | w_is_rem) & w_neg1 & (w_mag1 == w_min_mag) & w_s2 & (&w_op2);
  assign w_special = (w_op == 8'd0) | w_dz | w_ovf;

  always_comb begin
    w_special_res = '0;
    if (w_op == 8'd0)  w_special_res = '0;
    else if (w_dz)     w_special_res = w_is_div ? '1 : w_op1;
    else if (w_ovf)    w_special_res = w_is_div ? w_op1 : '0;
    if (w_word)        w_special_res = ext32(w_special_res, 1'b1);
  end

  logic [PW-1:0]   w_prod_nx, w_prod_s;
  logic [XLEN:0]   w_shift, w_diff;
  logic [XLEN-1:0] w_rem_nx, w_quo_nx, w_quo_s, w_rem_s, w_calc_res;

  assign w_prod_nx = r_mplier[0] ? (r_prod + r_mcand) : r_prod;
  assign w_shift   = {r_rem, r_quo[XLEN-1]};
  assign w_diff    = w_shift - {1'b0, r_dvs};
  assign w_rem_nx  = w_diff[XLEN] ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0];
  assign w_quo_nx  = {r_quo[XLEN-2:0], ~w_diff[XLEN]};
  assign w_prod_s  = r_neg_a ? -w_prod_nx : w_prod_nx;
  assign w_quo_s   = r_neg_a ? -w_quo_nx : w_quo_nx;
  assign w_rem_s   = r_neg_r ? -w_rem_nx : w_rem_nx;

  // Final result built from the last iteration's values so it lands in DONE with no extra cycle.
  always_comb begin
    w_calc_res = '0;
    if (r_is_div)      w_calc_res = w_quo_s;
    else if (r_is_rem) w_calc_res = w_rem_s;
    else if (r_mul_hi) w_calc_res = w_prod_s[PW-1:XLEN];
    else               w_calc_res = w_prod_s[XLEN-1:0];
    if (r_word)        w_calc_res = ext32(w_calc_res, 1'b1);
  end

  assign in_ready_o  = (r_state == S_IDLE) && !flush_i;
  assign busy_o      = (r_state != S_IDLE);
  assign dbg_state_o = r_state;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state     <= S_IDLE;
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_tag_o   <= '0;
      r_cnt       <= '0;
      r_word      <= 1'b0;
      r_is_div    <= 1'b0;
      r_is_rem    <= 1'b0;
      r_mul_hi    <= 1'b0;
      r_neg_a     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_prod      <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_dvs       <= '0;
    end else if (flush_i) begin
      r_state     <= S_IDLE;
      out_valid_o <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid_i) begin
            out_tag_o <= tag_i;
            r_word    <= w_word;
            r_is_div  <= w_is_div;
            r_is_rem  <= w_is_rem;
            r_mul_hi  <= w_mul_hi & w_is_mul;
            r_neg_a   <= w_neg1 ^ w_neg2;
            r_neg_r   <= w_neg1;
            r_prod    <= '0;
            r_mcand   <= {{XLEN{1'b0}}, w_mag1};
            r_mplier  <= w_mag2;
            r_rem     <= '0;
            r_quo     <= w_word ? (w_mag1 << 32) : w_mag1;
            r_dvs     <= w_mag2;
            r_cnt     <= w_word ? CW'(31) : CW'(XLEN - 1);
            if (w_special) begin
              out_data_o  <= w_special_res;
              out_valid_o <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_state     <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_prod   <= w_prod_nx;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_rem    <= w_rem_nx;
          r_quo    <= w_quo_nx;
          if (r_cnt == '0) begin
            out_data_o  <= w_calc_res;
            out_valid_o <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_DONE: begin
          if (out_ready_i) begin
            out_valid_o <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_execute_muldiv.sv
// Bench for execute_muldiv (XLEN=64): directed vector table, random ops against a behavioural
// model, and hand-written hold / flush / reset sequences.
module tb_execute_muldiv;
  localparam int XLEN  = 64;
  localparam int TAG_W = 5;
  localparam int TMO   = 200;

  logic             clk = 1'b0;
  logic             rst_n, flush, in_valid, in_ready, word, out_valid, out_ready, busy;
  logic [7:0]       md_op;
  logic [XLEN-1:0]  rs1, rs2, out_data;
  logic [TAG_W-1:0] tag, out_tag;
  logic [1:0]       dbg_state;

  int tests  = 0;
  int failed = 0;

  logic [XLEN-1:0]  exp_q[$];
  logic [TAG_W-1:0] tag_q[$];
  int               lat_q[$];

  typedef struct {
    logic [7:0]      op;
    logic            w;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] exp;
    int              lat;
  } vec_t;

  vec_t vecs[22];

  execute_muldiv #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .md_op_i(md_op), .word_i(word), .rs1_data_i(rs1), .rs2_data_i(rs2), .tag_i(tag),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data), .out_tag_o(out_tag),
    .busy_o(busy), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    failed++;
    $display("FAIL %s: timed out waiting for the DUT", name);
  endtask

  function automatic logic [63:0] sx32(input logic [31:0] x);
    return {{32{x[31]}}, x};
  endfunction

  // Reference model written from the ISA definition using native SV arithmetic.
  function automatic void model(input logic [7:0] op, input logic w, input logic [63:0] a,
                                input logic [63:0] b, output logic [63:0] r, output int lat);
    logic [7:0] o;
    logic [127:0] p;
    logic signed [63:0] sa, sb;
    logic signed [31:0] sa32, sb32;
    logic [31:0] a32, b32, q32, r32;
    logic [63:0] q64, r64;
    logic sg, wq;
    o = op & (~op + 8'd1);
    a32 = a[31:0]; b32 = b[31:0]; sa = a; sb = b; sa32 = a32; sb32 = b32;
    sg = o[4] | o[6]; wq = o[4] | o[5];
    lat = w ? 33 : 65;
    r = '0;
    if (o == 8'd0) begin
      lat = 1;
    end else if (|o[3:0]) begin
      if (w) begin
        p = {96'b0, a32} * {96'b0, b32};
        r = sx32(p[31:0]);
      end else if (o[0]) begin
        p = {64'b0, a} * {64'b0, b};
        r = p[63:0];
      end else begin
        p = {{64{a[63] & (o[1] | o[2])}}, a} * {{64{b[63] & o[1]}}, b};
        r = p[127:64];
      end
    end else if (w) begin
      if (b32 == 32'd0) begin lat = 1; q32 = '1; r32 = a32; end
      else if (sg && a32 == 32'h8000_0000 && b32 == '1) begin lat = 1; q32 = a32; r32 = '0; end
      else if (sg) begin q32 = sa32 / sb32; r32 = sa32 % sb32; end
      else begin q32 = a32 / b32; r32 = a32 % b32; end
      r = sx32(wq ? q32 : r32);
    end else begin
      if (b == 64'd0) begin lat = 1; q64 = '1; r64 = a; end
      else if (sg && a == 64'h8000_0000_0000_0000 && b == '1) begin lat = 1; q64 = a; r64 = '0; end
      else if (sg) begin q64 = sa / sb; r64 = sa % sb; end
      else begin q64 = a / b; r64 = a % b; end
      r = wq ? q64 : r64;
    end
  endfunction

  // Issue one op, wait for its result, check it, optionally stall the consumer, then consume.
  task automatic run_vec(input string nm, input logic [7:0] op, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] exp, input int exp_lat,
                         input logic [TAG_W-1:0] t, input int hold);
    int waitc, lat, el;
    logic [63:0] e;
    logic [TAG_W-1:0] et;
    waitc = 0;
    @(negedge clk);
    while (!in_ready && waitc < TMO) begin @(negedge clk); waitc++; end
    if (!in_ready) begin fail_now({nm, "_in_ready"}); return; end
    md_op = op; word = w; rs1 = a; rs2 = b; tag = t; in_valid = 1'b1;
    exp_q.push_back(exp); tag_q.push_back(t); lat_q.push_back(exp_lat);
    @(posedge clk);
    #1 in_valid = 1'b0; md_op = '0;
    lat = 1;
    @(negedge clk);
    if (exp_lat > 1) begin
      check({nm, "_busy"}, 64'(busy), 64'd1);
      check({nm, "_ready_low"}, 64'(in_ready), 64'd0);
    end
    while (!out_valid && lat < TMO) begin @(negedge clk); lat++; end
    e = exp_q.pop_front(); et = tag_q.pop_front(); el = lat_q.pop_front();
    if (!out_valid) begin fail_now({nm, "_out_valid"}); return; end
    check({nm, "_data"}, out_data, e);
    check({nm, "_tag"}, 64'(out_tag), 64'(et));
    check({nm, "_latency"}, 64'(lat), 64'(el));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check($sformatf("%s_hold%0d_data", nm, i), out_data, e);
      check($sformatf("%s_hold%0d_tag", nm, i), 64'(out_tag), 64'(et));
      check($sformatf("%s_hold%0d_valid", nm, i), 64'(out_valid), 64'd1);
      check($sformatf("%s_hold%0d_ready", nm, i), 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check({nm, "_valid_drop"}, 64'(out_valid), 64'd0);
    check({nm, "_ready_back"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [63:0] ra, rb, re;
    logic [7:0] rop;
    logic rw;
    int rl, idx, seen;

    vecs[0]  = '{8'h01, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65};
    vecs[1]  = '{8'h08, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65};
    vecs[2]  = '{8'h04, 1'b0, '1, 64'd2, '1, 65};
    vecs[3]  = '{8'h10, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65};
    vecs[4]  = '{8'h40, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, '1, 65};
    vecs[5]  = '{8'h20, 1'b0, 64'd100, 64'd7, 64'd14, 65};
    vecs[6]  = '{8'h20, 1'b0, 64'd5, 64'd0, '1, 1};
    vecs[7]  = '{8'h40, 1'b0, 64'd5, 64'd0, 64'd5, 1};
    vecs[8]  = '{8'h10, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1};
    vecs[9]  = '{8'h40, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 1};
    vecs[10] = '{8'h20, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, '1, 33};
    vecs[11] = '{8'h01, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33};
    vecs[12] = '{8'h00, 1'b0, 64'd123, 64'd45, 64'd0, 1};
    vecs[13] = '{8'h30, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 65};
    vecs[14] = '{8'h40, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, '1, 33};
    vecs[15] = '{8'h02, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33};
    vecs[16] = '{8'h10, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1};
    vecs[17] = '{8'h40, 1'b1, 64'h0000_0000_8000_0000, 64'd0, 64'hFFFF_FFFF_8000_0000, 1};
    vecs[18] = '{8'h02, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000, 65};
    vecs[19] = '{8'h80, 1'b1, 64'h1234_5678_9ABC_DEF0, 64'h100, 64'hF0, 33};
    vecs[20] = '{8'h20, 1'b1, 64'h1234_5678_9ABC_DEF0, 64'h100, 64'h009A_BCDE, 33};
    vecs[21] = '{8'hFF, 1'b0, '1, '1, 64'd1, 65};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    md_op = '0; word = 1'b0; rs1 = '0; rs2 = '0; tag = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_valid", 64'(out_valid), 64'd0);
    check("reset_data", out_data, 64'd0);
    check("reset_tag", 64'(out_tag), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_ready", 64'(in_ready), 64'd1);
    check("reset_state", 64'(dbg_state), 64'd0);

    for (int i = 0; i < 22; i++)
      run_vec($sformatf("vec%0d", i), vecs[i].op, vecs[i].w, vecs[i].a, vecs[i].b,
              vecs[i].exp, vecs[i].lat, TAG_W'(i + 1), 0);

    for (int i = 0; i < 24; i++) begin
      idx = $urandom_range(0, 8);
      rop = (idx == 8) ? 8'h00 : 8'(1 << idx);
      rw  = 1'($urandom_range(0, 1));
      ra  = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0:       rb = 64'($urandom_range(0, 5));
        1:       rb = '1;
        default: rb = {$urandom, $urandom};
      endcase
      model(rop, rw, ra, rb, re, rl);
      run_vec($sformatf("rnd%0d", i), rop, rw, ra, rb, re, rl, TAG_W'($urandom_range(0, 31)), 0);
    end

    run_vec("hold", 8'h01, 1'b0, 64'd3, 64'd5, 64'd15, 65, 5'd7, 5);

    // Flush a DIV during its tenth cycle.
    @(negedge clk);
    md_op = 8'h10; word = 1'b0; rs1 = 64'd1000; rs2 = 64'd3; tag = 5'd9; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0; md_op = '0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    #1 check("flush_ready_low", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_ready", 64'(in_ready), 64'd1);
    check("flush_valid", 64'(out_valid), 64'd0);
    check("flush_busy", 64'(busy), 64'd0);
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    check("flush_no_result", 64'(seen), 64'd0);

    // Reset a MUL during its twentieth cycle.
    md_op = 8'h01; word = 1'b0; rs1 = 64'd12345; rs2 = 64'd678; tag = 5'h15; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0; md_op = '0;
    repeat (19) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid_valid", 64'(out_valid), 64'd0);
    check("rst_mid_data", out_data, 64'd0);
    check("rst_mid_tag", 64'(out_tag), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_ready", 64'(in_ready), 64'd1);

    run_vec("post_reset", 8'h01, 1'b0, 64'd12345, 64'd678, 64'd8369910, 65, 5'h15, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
